// File: rtl/uart_txrx_core_if.sv
// Character-level handshake between the string formatter and the UART core.
// The master side issues tx_start/tx_data and consumes done/data_out.
interface uart_txrx_core_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [7:0] data_out;
    logic       rx_busy;
    logic       done;

    modport master (
        output tx_start, tx_data,
        input  tx_busy, data_out, rx_busy, done
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_busy, data_out, rx_busy, done
    );
endinterface

// File: rtl/uart_txrx_core.sv
// Full-duplex 8N1 UART: independent transmitter and receiver,
// each a two-process FSM clocked by clk at CLK_FREQ/BAUD clocks per bit.
module uart_txrx_core #(
    parameter int CLK_FREQ = 1_000_000,
    parameter int BAUD     = 9600
) (
    input  logic              clk,
    input  logic              rst,
    uart_txrx_core_if.slave   bus,
    output logic              tx,
    input  logic              rx
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_END  = 16'(DIV - 1);
    localparam logic [15:0] HALF_END = 16'(DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_idx, tx_idx_n;
    logic [7:0]  tx_shr, tx_shr_n;
    logic        tx_n;
    logic        tx_busy, tx_busy_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shr   <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shr   <= tx_shr_n;
            tx       <= tx_n;
            tx_busy  <= tx_busy_n;
        end
    end

    // tx is registered: the value computed here appears on the next edge
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_idx_n   = tx_idx;
        tx_shr_n   = tx_shr;
        tx_n       = tx;
        tx_busy_n  = tx_busy;
        unique case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                tx_n     = 1'b1;
                if (bus.tx_start) begin
                    tx_state_n = START;
                    tx_shr_n   = bus.tx_data;
                    tx_n       = 1'b0;
                    tx_busy_n  = 1'b1;
                end
            end
            START: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_n       = tx_shr[0];
                    tx_state_n = DATA;
                end
            end
            DATA: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n = '0;
                    tx_shr_n = {1'b0, tx_shr[7:1]};
                    if (tx_idx == 3'd7) begin
                        tx_n       = 1'b1;
                        tx_state_n = STOP;
                    end else begin
                        tx_n     = tx_shr[1];
                        tx_idx_n = tx_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_busy_n  = 1'b0;
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    logic        rx_s1, rx_s2, rx_prev;
    state_t      rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_idx, rx_idx_n;
    logic [7:0]  rx_shr, rx_shr_n;
    logic [7:0]  rx_data, rx_data_n;
    logic        rx_busy, rx_busy_n;
    logic        rx_done, rx_done_n;

    // synchronizer resets to the idle level so release never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shr   <= '0;
            rx_data  <= '0;
            rx_busy  <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shr   <= rx_shr_n;
            rx_data  <= rx_data_n;
            rx_busy  <= rx_busy_n;
            rx_done  <= rx_done_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_idx_n   = rx_idx;
        rx_shr_n   = rx_shr;
        rx_data_n  = rx_data;
        rx_busy_n  = rx_busy;
        rx_done_n  = 1'b0;
        unique case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) begin
                    rx_state_n = START;
                    rx_busy_n  = 1'b1;
                end
            end
            START: begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt_n = '0;
                    rx_idx_n = '0;
                    if (rx_s2) begin
                        rx_busy_n  = 1'b0;
                        rx_state_n = IDLE;
                    end else begin
                        rx_state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n = '0;
                    rx_shr_n = {rx_s2, rx_shr[7:1]};
                    if (rx_idx == 3'd7) begin
                        rx_state_n = STOP;
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_busy_n  = 1'b0;
                    rx_state_n = IDLE;
                    if (rx_s2) begin
                        rx_data_n = rx_shr;
                        rx_done_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

    assign bus.tx_busy  = tx_busy;
    assign bus.data_out = rx_data;
    assign bus.rx_busy  = rx_busy;
    assign bus.done     = rx_done;
endmodule

// File: tb/tb_uart_txrx_core.sv
// Directed bench for uart_txrx_core: frame tables with hand-written
// line patterns plus sequences for loopback, errors and mid-frame reset.
module tb_uart_txrx_core;
    localparam int DIV = 104;

    logic clk;
    logic rst;
    logic tx;
    logic rx;
    logic rx_drv;
    logic loop;
    logic abort;

    uart_txrx_core_if bus();

    uart_txrx_core #(.CLK_FREQ(1_000_000), .BAUD(9600)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx),
        .rx  (rx)
    );

    assign rx = loop ? tx : rx_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
    } txv_t;

    txv_t       txv[8];
    logic [7:0] rxv[5];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int         done_cnt = 0;
    int         wide_err = 0;
    int         busy_err = 0;
    logic       done_q = 1'b0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            rxq.push_back(bus.data_out);
            if (bus.rx_busy !== 1'b0) busy_err++;
            if (done_q === 1'b1) wide_err++;
        end
        done_q = bus.done;
    end

    function automatic logic [7:0] rxq_at(input int i);
        if (rxq.size() > i) return rxq[i];
        return 8'hxx;
    endfunction

    // called with tx_start already raised before the accepting edge
    task automatic tx_run(input logic [9:0] exp, input bit poke,
                          output int e_line, output int e_busy);
        e_line = 0;
        e_busy = 0;
        for (int c = 0; c < 10 * DIV; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.tx_start = 1'b0;
                bus.tx_data  = ~bus.tx_data;
            end
            if (poke && c == 300) begin
                bus.tx_start = 1'b1;
                bus.tx_data  = 8'hFF;
            end
            if (poke && c == 301) bus.tx_start = 1'b0;
            if (tx !== exp[c / DIV]) e_line++;
            if (bus.tx_busy !== 1'b1) e_busy++;
        end
        @(negedge clk);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            for (int k = 0; k < DIV; k++) begin
                @(negedge clk);
                if (abort) begin
                    rx_drv = 1'b1;
                    return;
                end
            end
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int el, eb, e, d0, n;
        bit seen;

        txv[0] = '{8'h53, 10'b1010100110};
        txv[1] = '{8'h3A, 10'b1001110100};
        txv[2] = '{8'h32, 10'b1001100100};
        txv[3] = '{8'h35, 10'b1001101010};
        txv[4] = '{8'h2F, 10'b1001011110};
        txv[5] = '{8'h41, 10'b1010000010};
        txv[6] = '{8'h4C, 10'b1010011000};
        txv[7] = '{8'h5A, 10'b1010110100};
        rxv[0] = 8'h4C;
        rxv[1] = 8'h31;
        rxv[2] = 8'h3A;
        rxv[3] = 8'h30;
        rxv[4] = 8'h2F;

        rst          = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        rx_drv       = 1'b1;
        loop         = 1'b0;
        abort        = 1'b0;

        repeat (5) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_tx_busy", bus.tx_busy, 0);
        chk("rst_rx_busy", bus.rx_busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_data_out", bus.data_out, 8'h00);
        rst = 1'b0;

        e = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.done !== 1'b0)
                e++;
        end
        chk("idle_quiet", e, 0);
        chk("idle_data_out", bus.data_out, 8'h00);

        bus.tx_data  = txv[0].d;
        bus.tx_start = 1'b1;
        @(posedge clk);
        #1;
        chk("tx_busy_rise", bus.tx_busy, 1);
        chk("tx_line_rise", tx, 0);
        tx_run(txv[0].frame, 1'b1, el, eb);
        chk("single_line", el, 0);
        chk("single_busy", eb, 0);
        chk("single_busy_drop", bus.tx_busy, 0);
        e = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.tx_busy !== 1'b0 || tx !== 1'b1) e++;
        end
        chk("no_queued_start", e, 0);

        for (int i = 0; i < 5; i++) begin
            bus.tx_data  = txv[i].d;
            bus.tx_start = 1'b1;
            tx_run(txv[i].frame, 1'b0, el, eb);
            chk($sformatf("b2b_line_%0d", i), el, 0);
            chk($sformatf("b2b_busy_%0d", i), eb, 0);
            chk($sformatf("b2b_gap_%0d", i), {tx, bus.tx_busy}, 2'b10);
        end

        repeat (20) @(negedge clk);
        loop = 1'b1;
        rxq.delete();
        d0 = done_cnt;
        for (int i = 5; i < 7; i++) begin
            bus.tx_data  = txv[i].d;
            bus.tx_start = 1'b1;
            tx_run(txv[i].frame, 1'b0, el, eb);
            chk($sformatf("loop_line_%0d", i), el, 0);
        end
        repeat (50) @(negedge clk);
        loop = 1'b0;
        chk("loop_done_cnt", done_cnt - d0, 2);
        chk("loop_byte0", rxq_at(0), 8'h41);
        chk("loop_byte1", rxq_at(1), 8'h4C);
        chk("loop_data_out", bus.data_out, 8'h4C);

        repeat (20) @(negedge clk);
        rxq.delete();
        d0 = done_cnt;
        fork
            begin
                for (int i = 0; i < 5; i++) drive_rx(rxv[i], 1'b1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    bus.tx_data  = txv[i].d;
                    bus.tx_start = 1'b1;
                    tx_run(txv[i].frame, 1'b0, el, eb);
                    chk($sformatf("dup_tx_line_%0d", i), el, 0);
                end
            end
        join
        repeat (50) @(negedge clk);
        chk("dup_done_cnt", done_cnt - d0, 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("dup_rx_byte_%0d", i), rxq_at(i), rxv[i]);

        d0   = done_cnt;
        seen = 1'b0;
        rx_drv = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.rx_busy === 1'b1) seen = 1'b1;
        end
        rx_drv = 1'b1;
        n = 0;
        while (bus.rx_busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("false_start_busy_seen", seen, 1);
        chk("false_start_in_time", (30 + n) <= 60, 1);
        repeat (200) @(negedge clk);
        chk("false_start_no_done", done_cnt - d0, 0);

        drive_rx(8'h99, 1'b0);
        repeat (300) @(negedge clk);
        chk("frame_err_no_done", done_cnt - d0, 0);
        chk("frame_err_data_kept", bus.data_out, 8'h2F);
        chk("frame_err_rx_busy", bus.rx_busy, 0);

        d0 = done_cnt;
        fork
            drive_rx(8'hA5, 1'b1);
            begin
                bus.tx_data  = 8'h5A;
                bus.tx_start = 1'b1;
                @(negedge clk);
                bus.tx_start = 1'b0;
                repeat (4 * DIV + 49) @(negedge clk);
                rst   = 1'b1;
                abort = 1'b1;
                #1;
                chk("mid_rst_tx", tx, 1);
                chk("mid_rst_tx_busy", bus.tx_busy, 0);
                chk("mid_rst_rx_busy", bus.rx_busy, 0);
            end
        join
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        abort = 1'b0;
        repeat (300) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_data_out", bus.data_out, 8'h00);

        fork
            drive_rx(8'hA5, 1'b1);
            begin
                bus.tx_data  = txv[7].d;
                bus.tx_start = 1'b1;
                tx_run(txv[7].frame, 1'b0, el, eb);
                chk("post_rst_tx_line", el, 0);
                chk("post_rst_tx_busy", eb, 0);
            end
        join
        repeat (50) @(negedge clk);
        chk("post_rst_done_cnt", done_cnt - d0, 1);
        chk("post_rst_data_out", bus.data_out, 8'hA5);

        chk("done_width", wide_err, 0);
        chk("done_rx_busy_low", busy_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_txrx_core.md
Name: uart_txrx_core

Overview:
- Full-duplex 8N1 UART core: one transmitter, one receiver, sharing a single clock and reset.
- Sits under the string-level UART formatter. That formatter drives one character at a time via a start/busy handshake and consumes received bytes via a done pulse.
- Nominal operation: 1 MHz clock, 9600 baud. No parity, LSB first, one stop bit.

Parameters:
- CLK_FREQ, 1_000_000, clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DIV (derived, localparam), CLK_FREQ/BAUD with integer truncation (104 at defaults), clocks per bit.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- tx_start  in  1  request to send tx_data; a single-cycle pulse is sufficient.
- tx_data  in  8  byte to transmit; sampled only on the accepting edge.
- tx  out  1  serial output; idle high.
- tx_busy  out  1  high while a frame is being transmitted.
- rx  in  1  serial input; asynchronous to clk.
- data_out  out  8  last correctly received byte.
- rx_busy  out  1  high while a frame is being received.
- done  out  1  one-cycle pulse when data_out is updated.

Behaviour:
- Reset (asynchronous, active-high) forces these values; reset mid-frame aborts the frame with no done pulse and no partial data_out update:
  - tx=1, tx_busy=0.
  - data_out=0x00, rx_busy=0, done=0.
  - Both FSMs return to IDLE; counters cleared.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. On an edge where tx_start=1, latch tx_data and set tx_busy=1 on that same edge; the line goes low (start bit) from that edge.
  - tx_start while tx_busy=1 is ignored and not queued.
  - START: tx=0 for DIV cycles.
  - DATA: bits 0..7, LSB first, DIV cycles each.
  - STOP: tx=1 for DIV cycles. At its end tx_busy drops to 0 and the FSM returns to IDLE.
  - tx_busy is high for exactly 10*DIV cycles per frame (1040 at defaults).
  - Back-to-back: tx_start asserted in the first cycle tx_busy=0 starts the next frame immediately; tx stays high through that cycle.
  - Changes on tx_data after acceptance do not affect the frame in flight.
- RX FSM states: IDLE, START, DATA, STOP.
  - rx passes through a 2-flop synchronizer before use; all decisions use the synchronized value.
  - IDLE: a synchronized 1->0 transition enters START and sets rx_busy=1.
  - START: wait DIV/2 cycles (integer), then re-sample. If rx is high it is a false start: clear rx_busy, return to IDLE. If low, go to DATA.
  - DATA: sample every DIV cycles at the mid-bit point; shift in 8 bits LSB first.
  - STOP: sample after DIV cycles.
    - If the stop bit is high: load data_out, pulse done=1 for exactly one cycle, clear rx_busy on the same edge.
    - If it is low (framing error): clear rx_busy, no done, data_out unchanged.
    - Either way return to IDLE.
  - Consequence for consumers: in the done cycle rx_busy=0, so the qualifier (done && !rx_busy) is true exactly once per valid byte.
  - data_out holds its value until the next valid frame.
  - After the stop sample, a new start edge is accepted immediately, including one that continues the stop bit's back half.
- TX and RX are fully independent; simultaneous activity has no interaction.
- Internal counters: bit counter 16 bits wide minimum, sized for DIV up to 65535; bit index 3 bits wide.

Test Plan:
- Idle after reset: hold rst=1 for 5 cycles, release with tx_start=0 for 2000 cycles. Require tx=1, tx_busy=0, done=0 throughout, and data_out=0x00.
- Single TX frame: tx_start pulse for 1 cycle with tx_data=0x53. Require:
  - tx_busy rises on that edge and stays high for exactly 1040 cycles.
  - tx sequence, 104 cycles per bit: 0 | 1,1,0,0,1,0,1,0 | 1.
  - A second tx_start mid-frame is ignored.
- Back-to-back TX: replay the formatter handshake for "S:25" plus "/" (0x53,0x3A,0x32,0x35,0x2F). Require five contiguous frames with no lost or duplicated bytes.
- RX with loopback and simultaneous traffic: drive rx from tx, sending 0x41 then 0x4C. Also drive the five-byte "L1:0/" sequence on rx while TX is sending concurrently. Require:
  - done pulses exactly once per byte, each one cycle wide with rx_busy=0.
  - data_out equals 0x41 and then 0x4C for the loopback bytes.
  - The "L1:0/" bytes are all received correctly.
- RX error cases:
  - rx low for 30 cycles, then high: false start; no done; rx_busy returns to 0 within about 52 cycles.
  - Frame with stop bit 0: no done; data_out keeps its previous value.
- Reset mid-frame: assert rst during the 4th data bit of both a TX and an RX frame. Require:
  - Immediate tx=1, tx_busy=0, rx_busy=0.
  - No done pulse.
  - The next full frame after release transmits and receives correctly.
